// File: rtl/ddr3_init_pkg.sv
// Shared constants and types for the DDR3 power-up sequencer: DFII register map,
// control/command encodings and the step-table record.
package ddr3_init_pkg;

  localparam int unsigned NUM_STEPS = 27;

  localparam logic [7:0] OFS_CONTROL  = 8'h00;
  localparam logic [7:0] OFS_COMMAND  = 8'h04;
  localparam logic [7:0] OFS_ADDRESS  = 8'h0C;
  localparam logic [7:0] OFS_BADDRESS = 8'h10;

  localparam logic [31:0] CTRL_SEL     = 32'h1;
  localparam logic [31:0] CTRL_CKE     = 32'h2;
  localparam logic [31:0] CTRL_ODT     = 32'h4;
  localparam logic [31:0] CTRL_RESET_N = 32'h8;

  localparam logic [31:0] CMD_CS  = 32'h1;
  localparam logic [31:0] CMD_WE  = 32'h2;
  localparam logic [31:0] CMD_CAS = 32'h4;
  localparam logic [31:0] CMD_RAS = 32'h8;

  typedef enum logic {OP_WRITE, OP_WAIT} step_op_e;

  typedef enum logic [2:0] {
    WaitReset, WaitCke, WaitMrd, WaitMod, WaitZqinit
  } wait_sel_e;

  // For OP_WRITE, arg is the data word; for OP_WAIT, arg holds a wait_sel_e.
  typedef struct packed {
    step_op_e    op;
    logic [7:0]  offset;
    logic [31:0] arg;
  } step_t;

  typedef enum logic [2:0] {
    StIdle, StFetch, StWrite, StWait, StDone, StError
  } state_e;

  function automatic step_t mk_write(logic [7:0] offset, logic [31:0] data);
    step_t s;
    s.op     = OP_WRITE;
    s.offset = offset;
    s.arg    = data;
    return s;
  endfunction

  function automatic step_t mk_wait(wait_sel_e sel);
    step_t s;
    s.op     = OP_WAIT;
    s.offset = '0;
    s.arg    = 32'(sel);
    return s;
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_init_wb_write.sv
// Single-beat Wishbone write engine: latches addr/data on req, holds the cycle until
// ack, err or timeout, and reports the outcome as a one-cycle ok/fail pulse.
module ddr3_init_wb_write
  import ddr3_init_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        ok,
  output logic        fail,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  input  logic        wb_ack,
  input  logic        wb_err
);

  localparam int unsigned Limit = (ACK_TIMEOUT == 0) ? 1 : ACK_TIMEOUT;
  localparam int unsigned TW    = max_u(8, $clog2(Limit + 1));

  logic          cyc_q, cyc_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0]   adr_q, adr_d, dat_q, dat_d;
  logic          timeout;

  assign timeout = (cnt_q == TW'(Limit - 1));

  // err beats ack; an ack arriving on the last allowed cycle still counts.
  always_comb begin
    cyc_d = cyc_q;
    cnt_d = cnt_q;
    adr_d = adr_q;
    dat_d = dat_q;
    ok    = 1'b0;
    fail  = 1'b0;
    if (cyc_q) begin
      if (wb_err) begin
        fail  = 1'b1;
        cyc_d = 1'b0;
      end else if (wb_ack) begin
        ok    = 1'b1;
        cyc_d = 1'b0;
      end else if (timeout) begin
        fail  = 1'b1;
        cyc_d = 1'b0;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end else if (req) begin
      cyc_d = 1'b1;
      cnt_d = '0;
      adr_d = addr;
      dat_d = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 1'b0;
      cnt_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      cnt_q <= cnt_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign wb_cyc   = cyc_q;
  assign wb_stb   = cyc_q;
  assign wb_we    = cyc_q;
  assign wb_sel   = {4{cyc_q}};
  assign wb_adr   = adr_q;
  assign wb_dat_w = dat_q;

endmodule

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up sequencer: walks a fixed table of DFII CSR writes and timed waits,
// then hands the DFI back to the hardware controller.
module ddr3_init_seq
  import ddr3_init_pkg::*;
#(
  parameter logic [31:0] CSR_BASE     = 32'h0000_9000,
  parameter int unsigned T_RESET_CYC  = 50000,
  parameter int unsigned T_CKE_CYC    = 50000,
  parameter int unsigned T_MRD_CYC    = 4,
  parameter int unsigned T_MOD_CYC    = 12,
  parameter int unsigned T_ZQINIT_CYC = 512,
  parameter logic [15:0] MR0_VAL      = 16'h0520,
  parameter logic [15:0] MR1_VAL      = 16'h0006,
  parameter logic [15:0] MR2_VAL      = 16'h0200,
  parameter logic [15:0] MR3_VAL      = 16'h0000,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  step,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  input  logic        wb_ack,
  input  logic        wb_err
);

  localparam int unsigned TMax = max_u(max_u(max_u(T_RESET_CYC, T_CKE_CYC),
                                             max_u(T_MRD_CYC, T_MOD_CYC)), T_ZQINIT_CYC);
  localparam int unsigned WW = max_u(1, $clog2(TMax + 1));
  localparam logic [4:0] LastStep = 5'(NUM_STEPS - 1);

  localparam logic [31:0] CtrlReset = CTRL_ODT | CTRL_RESET_N;
  localparam logic [31:0] CtrlCke   = CTRL_CKE | CTRL_ODT | CTRL_RESET_N;
  localparam logic [31:0] CmdMrs    = CMD_CS | CMD_WE | CMD_CAS | CMD_RAS;
  localparam logic [31:0] CmdZqcl   = CMD_CS | CMD_WE;

  state_e        state_q, state_d;
  logic [4:0]    step_q, step_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [WW-1:0] wait_len;
  step_t         cur;
  logic          req, wr_ok, wr_fail;

  always_comb begin
    cur = '0;
    case (step_q)
      5'd0:    cur = mk_write(OFS_CONTROL, CtrlReset);
      5'd1:    cur = mk_write(OFS_ADDRESS, 32'h0);
      5'd2:    cur = mk_write(OFS_BADDRESS, 32'h0);
      5'd3:    cur = mk_wait(WaitReset);
      5'd4:    cur = mk_write(OFS_CONTROL, CtrlCke);
      5'd5:    cur = mk_wait(WaitCke);
      5'd6:    cur = mk_write(OFS_ADDRESS, 32'(MR2_VAL));
      5'd7:    cur = mk_write(OFS_BADDRESS, 32'd2);
      5'd8:    cur = mk_write(OFS_COMMAND, CmdMrs);
      5'd9:    cur = mk_wait(WaitMrd);
      5'd10:   cur = mk_write(OFS_ADDRESS, 32'(MR3_VAL));
      5'd11:   cur = mk_write(OFS_BADDRESS, 32'd3);
      5'd12:   cur = mk_write(OFS_COMMAND, CmdMrs);
      5'd13:   cur = mk_wait(WaitMrd);
      5'd14:   cur = mk_write(OFS_ADDRESS, 32'(MR1_VAL));
      5'd15:   cur = mk_write(OFS_BADDRESS, 32'd1);
      5'd16:   cur = mk_write(OFS_COMMAND, CmdMrs);
      5'd17:   cur = mk_wait(WaitMrd);
      5'd18:   cur = mk_write(OFS_ADDRESS, 32'(MR0_VAL));
      5'd19:   cur = mk_write(OFS_BADDRESS, 32'd0);
      5'd20:   cur = mk_write(OFS_COMMAND, CmdMrs);
      5'd21:   cur = mk_wait(WaitMod);
      5'd22:   cur = mk_write(OFS_ADDRESS, 32'h400);
      5'd23:   cur = mk_write(OFS_BADDRESS, 32'h0);
      5'd24:   cur = mk_write(OFS_COMMAND, CmdZqcl);
      5'd25:   cur = mk_wait(WaitZqinit);
      5'd26:   cur = mk_write(OFS_CONTROL, CTRL_SEL);
      default: cur = '0;
    endcase
  end

  always_comb begin
    wait_len = '0;
    case (wait_sel_e'(cur.arg[2:0]))
      WaitReset:  wait_len = WW'(T_RESET_CYC);
      WaitCke:    wait_len = WW'(T_CKE_CYC);
      WaitMrd:    wait_len = WW'(T_MRD_CYC);
      WaitMod:    wait_len = WW'(T_MOD_CYC);
      WaitZqinit: wait_len = WW'(T_ZQINIT_CYC);
      default:    wait_len = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wcnt_d  = wcnt_q;
    req     = 1'b0;
    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StFetch;
          step_d  = '0;
        end
      end
      StFetch: begin
        if (cur.op == OP_WRITE) begin
          req     = 1'b1;
          state_d = StWrite;
        end else begin
          // Counter runs down to zero, so a zero-length wait still takes one cycle.
          wcnt_d  = (wait_len == '0) ? '0 : wait_len - WW'(1);
          state_d = StWait;
        end
      end
      StWrite: begin
        if (wr_fail) begin
          state_d = StError;
        end else if (wr_ok) begin
          if (step_q == LastStep) begin
            state_d = StDone;
          end else begin
            step_d  = step_q + 5'd1;
            state_d = StFetch;
          end
        end
      end
      StWait: begin
        if (wcnt_q == '0) begin
          if (step_q == LastStep) begin
            state_d = StDone;
          end else begin
            step_d  = step_q + 5'd1;
            state_d = StFetch;
          end
        end else begin
          wcnt_d = wcnt_q - WW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign busy  = (state_q == StFetch) || (state_q == StWrite) || (state_q == StWait);
  assign done  = (state_q == StDone);
  assign error = (state_q == StError);
  assign step  = step_q;

  ddr3_init_wb_write #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_wb_write (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr     (CSR_BASE + 32'(cur.offset)),
    .data     (cur.arg),
    .ok       (wr_ok),
    .fail     (wr_fail),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_dat_w (wb_dat_w),
    .wb_sel   (wb_sel),
    .wb_ack   (wb_ack),
    .wb_err   (wb_err)
  );

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Bench for ddr3_init_seq: random-latency Wishbone slave, error/timeout injection and
// an expected write list with cycle timing built from the init sequence description.
module tb_ddr3_init_seq;

  localparam int unsigned TR = 7, TC = 5, TMRD = 3, TMOD = 0, TZQ = 6, TO = 10;
  localparam logic [31:0] BASE = 32'h0000_9000;
  localparam int ModeOk = 0, ModeErr = 1, ModeBoth = 2, ModeHang = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [4:0]  step;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;

  ddr3_init_seq #(
    .CSR_BASE     (BASE),
    .T_RESET_CYC  (TR),
    .T_CKE_CYC    (TC),
    .T_MRD_CYC    (TMRD),
    .T_MOD_CYC    (TMOD),
    .T_ZQINIT_CYC (TZQ),
    .ACK_TIMEOUT  (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .step     (step),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_dat_w (wb_dat_w),
    .wb_sel   (wb_sel),
    .wb_ack   (wb_ack),
    .wb_err   (wb_err)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected writes, their step index, and extra cycles spent in
  // waits between the previous write and this one.
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  int          exp_step[$];
  int          exp_gap[$];
  int          m_step = 0;
  int          m_gap  = 0;

  task automatic add_w(input logic [7:0] off, input logic [31:0] d);
    exp_adr.push_back(BASE + {24'h0, off});
    exp_dat.push_back(d);
    exp_step.push_back(m_step);
    exp_gap.push_back(m_gap);
    m_gap = 0;
    m_step++;
  endtask

  task automatic add_d(input int n);
    m_gap += 1 + ((n == 0) ? 1 : n);
    m_step++;
  endtask

  task automatic add_mrs(input logic [15:0] mr, input int ba, input int n);
    add_w(8'h0C, {16'h0, mr});
    add_w(8'h10, ba);
    add_w(8'h04, 32'h0F);
    add_d(n);
  endtask

  task automatic build_model();
    add_w(8'h00, 32'h0C);
    add_w(8'h0C, 32'h0);
    add_w(8'h10, 32'h0);
    add_d(TR);
    add_w(8'h00, 32'h0E);
    add_d(TC);
    add_mrs(16'h0200, 2, TMRD);
    add_mrs(16'h0000, 3, TMRD);
    add_mrs(16'h0006, 1, TMRD);
    add_mrs(16'h0520, 0, TMOD);
    add_w(8'h0C, 32'h400);
    add_w(8'h10, 32'h0);
    add_w(8'h04, 32'h03);
    add_d(TZQ);
    add_w(8'h00, 32'h01);
  endtask

  // Slave state and observation logs.
  int          s_mode = ModeOk, s_tgt = -1, s_lat = 0, s_cnt = 0, w_att = 0, first_stb = -1;
  bit          after_resp = 1'b0;
  int          n_proto = 0, n_unstable = 0;
  logic [31:0] cap_adr, cap_dat;
  logic [31:0] got_adr[$];
  logic [31:0] got_dat[$];
  logic [4:0]  got_ws[$];
  int          got_cyc[$];
  int          got_lat[$];

  initial begin
    forever begin
      @(negedge clk);
      wb_ack = 1'b0;
      wb_err = 1'b0;
      if (!rst_n) begin
        s_cnt      = 0;
        after_resp = 1'b0;
      end else if (after_resp) begin
        if (wb_cyc) n_proto++;
        after_resp = 1'b0;
      end else if (wb_cyc && wb_stb) begin
        if (s_cnt == 0) begin
          cap_adr = wb_adr;
          cap_dat = wb_dat_w;
          if (first_stb < 0) first_stb = cyc_n;
        end else if (wb_adr !== cap_adr || wb_dat_w !== cap_dat) begin
          n_unstable++;
        end
        if (s_mode != ModeHang && s_cnt >= s_lat) begin
          if (w_att == s_tgt && s_mode == ModeErr) begin
            wb_err = 1'b1;
          end else if (w_att == s_tgt && s_mode == ModeBoth) begin
            wb_ack = 1'b1;
            wb_err = 1'b1;
          end else begin
            wb_ack = 1'b1;
            got_adr.push_back(wb_adr);
            got_dat.push_back(wb_dat_w);
            got_ws.push_back({wb_we, wb_sel});
            got_cyc.push_back(cyc_n + 1);
            got_lat.push_back(s_lat);
          end
          w_att++;
          s_cnt      = 0;
          s_lat      = $urandom_range(0, 3);
          after_resp = 1'b1;
        end else begin
          s_cnt++;
        end
      end else begin
        s_cnt = 0;
      end
    end
  end

  task automatic arm(input int mode, input int tgt);
    s_mode     = mode;
    s_tgt      = tgt;
    w_att      = 0;
    s_cnt      = 0;
    s_lat      = $urandom_range(0, 3);
    first_stb  = -1;
    n_proto    = 0;
    n_unstable = 0;
    got_adr.delete();
    got_dat.delete();
    got_ws.delete();
    got_cyc.delete();
    got_lat.delete();
  endtask

  task automatic run_seq(input int mode, input int tgt, input bit noisy,
                         output int start_pos, output int end_cyc, output bit finished);
    arm(mode, tgt);
    @(negedge clk);
    start     = 1'b1;
    start_pos = cyc_n + 1;
    @(negedge clk);
    start    = 1'b0;
    finished = 1'b0;
    end_cyc  = -1;
    for (int i = 0; i < 1000; i++) begin
      if (done || error) begin
        finished = 1'b1;
        end_cyc  = cyc_n;
        break;
      end
      @(negedge clk);
      start = 1'b0;
      if (noisy && busy && $urandom_range(0, 7) == 0) start = 1'b1;
    end
  endtask

  task automatic check_clean(input string tag, input int start_pos, input bit finished);
    int prev;
    int n;
    check_eq({tag, "_finished"}, finished, 1);
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_error"}, error, 0);
    check_eq({tag, "_nwrites"}, got_adr.size(), exp_adr.size());
    check_eq({tag, "_cyc_drop"}, n_proto, 0);
    check_eq({tag, "_stable"}, n_unstable, 0);
    n = (got_adr.size() < exp_adr.size()) ? got_adr.size() : exp_adr.size();
    prev = start_pos;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_adr[%0d]", tag, i), got_adr[i], exp_adr[i]);
      check_eq($sformatf("%s_dat[%0d]", tag, i), got_dat[i], exp_dat[i]);
      check_eq($sformatf("%s_we_sel[%0d]", tag, i), got_ws[i], 5'h1F);
      check_eq($sformatf("%s_time[%0d]", tag, i), got_cyc[i],
               prev + 2 + got_lat[i] + exp_gap[i]);
      prev = got_cyc[i];
    end
  endtask

  initial begin
    int  sp, ec, tgt;
    bit  fin;
    bit  found;

    build_model();

    #12;
    check_eq("reset_outs", {busy, done, error, step, wb_cyc, wb_stb, wb_we, wb_sel}, 0);
    check_eq("reset_bus", {wb_adr, wb_dat_w}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", busy, 0);

    // Clean run with random slave latency and stray start pulses while busy.
    run_seq(ModeOk, -1, 1'b1, sp, ec, fin);
    check_clean("run1", sp, fin);

    // Bus error on the MR2 command write.
    tgt = -1;
    for (int i = 0; i < exp_step.size(); i++) if (exp_step[i] == 8) tgt = i;
    run_seq(ModeErr, tgt, 1'b0, sp, ec, fin);
    check_eq("err_finished", fin, 1);
    check_eq("err_flags", {busy, done, error}, 3'b001);
    check_eq("err_step", step, 8);
    check_eq("err_nwrites", got_adr.size(), tgt);
    check_eq("err_cyc_drop", n_proto, 0);
    repeat (20) @(negedge clk);
    check_eq("err_no_more", w_att, tgt + 1);
    check_eq("err_sticky", {error, wb_cyc}, 2'b10);

    // Restart after error: full clean run.
    run_seq(ModeOk, -1, 1'b1, sp, ec, fin);
    check_clean("run2", sp, fin);

    // Slave that never acks.
    run_seq(ModeHang, -1, 1'b0, sp, ec, fin);
    check_eq("to_finished", fin, 1);
    check_eq("to_flags", {busy, done, error}, 3'b001);
    check_eq("to_step", step, 0);
    check_eq("to_latency", ec - first_stb, TO);
    check_eq("to_nwrites", got_adr.size(), 0);

    // ack and err together on the first write.
    run_seq(ModeBoth, 0, 1'b0, sp, ec, fin);
    check_eq("both_flags", {busy, done, error}, 3'b001);
    check_eq("both_step", step, 0);

    // Asynchronous reset in the middle of the wait at step 13.
    arm(ModeOk, -1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (step == 5'd13 && busy) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    check_eq("rst_found", {found, step}, {1'b1, 5'd13});
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_outs", {busy, done, error, step, wb_cyc, wb_stb, wb_we, wb_sel}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(ModeOk, -1, 1'b0, sp, ec, fin);
    check_clean("run3", sp, fin);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
